// File: rtl/cpu_ctrl_fsm_param.sv
// Multicycle control FSM for the CR16-subset CPU. It holds the instruction and flag registers and
// sequences fetch, decode, execute, memory and writeback, with an optional memory-ready handshake.
module cpu_ctrl_fsm_param #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned IMM_W       = 8,
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned FLAG_W      = 5,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [15:0]           Instr,
  input  logic [FLAG_W-1:0]     ALUFlags,
  input  logic                  MemReady,
  output logic                  IREn,
  output logic                  Imm_s,
  output logic [IMM_W-1:0]      Imm,
  output logic                  Signed,
  output logic [ALU_OP_W-1:0]   ALUOpCode,
  output logic [REG_ADDR_W-1:0] RdestRegLoc,
  output logic [REG_ADDR_W-1:0] RsrcRegLoc,
  output logic                  RegEn,
  output logic                  LoadInSelect,
  output logic                  RAMEn,
  output logic                  RamAddrSelect,
  output logic                  PCEn,
  output logic [1:0]            PCSel,
  output logic                  Halted,
  output logic [2:0]            State
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMemRd  = 3'd3;
  localparam logic [2:0] StMemWr  = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [3:0] opcode, ext, cond, alu_op;
  logic       is_rr, is_alu_rr, is_alu_imm, is_load, is_stor, is_jcond, is_bcond;
  logic       mem_done, take;

  function automatic logic alu_code_valid(input logic [3:0] c);
    case (c)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Flags are ordered {N,Z,F,L,C}.
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    case (c)
      4'd0:    return f[3];
      4'd1:    return !f[3];
      4'd2:    return f[0];
      4'd3:    return !f[0];
      4'd4:    return f[1];
      4'd5:    return !f[1];
      4'd6:    return f[4];
      4'd7:    return !f[4];
      4'd8:    return f[2];
      4'd9:    return !f[2];
      4'd10:   return !f[1] && !f[3];
      4'd11:   return f[1] || f[3];
      4'd12:   return !f[4] && !f[3];
      4'd13:   return f[4] || f[3];
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign opcode     = ir_q[15:12];
  assign ext        = ir_q[7:4];
  assign cond       = ir_q[11:8];
  assign is_rr      = (opcode == 4'h0);
  assign is_alu_rr  = is_rr && alu_code_valid(ext);
  assign is_alu_imm = !is_rr && (alu_code_valid(opcode) || opcode == 4'hF);
  assign is_load    = (opcode == 4'h4) && (ext == 4'h0);
  assign is_stor    = (opcode == 4'h4) && (ext == 4'h4);
  assign is_jcond   = (opcode == 4'h4) && (ext == 4'hC);
  assign is_bcond   = (opcode == 4'hC);
  assign alu_op     = is_rr ? ext : opcode;
  assign mem_done   = MemReady || !MEM_WAIT_EN;
  assign take       = cond_true(cond, flags_q[4:0]);

  assign Imm         = ir_q[IMM_W-1:0];
  assign RdestRegLoc = REG_ADDR_W'(ir_q[11:8]);
  assign RsrcRegLoc  = REG_ADDR_W'(ir_q[3:0]);
  assign State       = state_q;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    flags_d       = flags_q;
    IREn          = 1'b0;
    Imm_s         = 1'b0;
    Signed        = 1'b0;
    ALUOpCode     = '0;
    RegEn         = 1'b0;
    LoadInSelect  = 1'b0;
    RAMEn         = 1'b0;
    RamAddrSelect = 1'b0;
    PCEn          = 1'b0;
    PCSel         = 2'b00;
    Halted        = 1'b0;
    // Gate on Reset_n so every output reads 0 while reset is held, even combinational ones.
    if (Reset_n) begin
      case (state_q)
        StFetch: begin
          if (mem_done) begin
            IREn    = 1'b1;
            ir_d    = Instr;
            state_d = StDecode;
          end
        end
        StDecode: begin
          if (ir_q == 16'h0000) state_d = StHalt;
          else if (is_load)     state_d = StMemRd;
          else if (is_stor)     state_d = StMemWr;
          else                  state_d = StExec;
        end
        StExec: begin
          PCEn    = 1'b1;
          state_d = StFetch;
          if (is_alu_rr || is_alu_imm) begin
            Imm_s     = is_alu_imm;
            Signed    = is_alu_imm && (alu_op == 4'h5 || alu_op == 4'h9 || alu_op == 4'hB);
            ALUOpCode = ALU_OP_W'(alu_op);
            RegEn     = (alu_op != 4'hB);
            flags_d   = ALUFlags;
          end else if (is_bcond) begin
            PCSel = take ? 2'b01 : 2'b00;
          end else if (is_jcond) begin
            PCSel = take ? 2'b10 : 2'b00;
          end
        end
        StMemRd: begin
          RamAddrSelect = 1'b1;
          if (mem_done) state_d = StWb;
        end
        StWb: begin
          LoadInSelect = 1'b1;
          RegEn        = 1'b1;
          PCEn         = 1'b1;
          state_d      = StFetch;
        end
        StMemWr: begin
          RamAddrSelect = 1'b1;
          RAMEn         = 1'b1;
          if (mem_done) begin
            PCEn    = 1'b1;
            state_d = StFetch;
          end
        end
        StHalt: Halted = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StFetch;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule
